// File: rtl/catc_exec_unit.sv
// catc_exec_unit: operand registers A/B, result memory, single-cycle ALU ops and a serial shift-add multiplier.
// Latency: LDA/LDB/ALU/RD complete at the accept edge; MUL writes on the WIDTH-th edge after accept. op_done and out_valid pulse one cycle later.
// Backpressure: cmd_ready drops for exactly WIDTH cycles during MUL; commands offered while it is low are ignored.
// Optional macro CATC_EXEC_SAT_EN: saturating ADD/SUB/MUL results (overflow -> all-ones, borrow -> zero).
module catc_exec_unit #(
  parameter int WIDTH     = 20,
  parameter int MEM_DEPTH = 16,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             op_done,
  output logic             ovf
);

  localparam logic [2:0] OP_LDA = 3'd0;
  localparam logic [2:0] OP_LDB = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_RD  = 3'd7;

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t state, next_state;
  logic   state_ready;
  logic   accept;
  logic   last_step;

  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] mem [MEM_DEPTH];

  // Multiplier state: prod holds {partial high half, remaining multiplier bits}.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [AW-1:0]      mul_addr;
  logic [CW-1:0]      step_cnt;

  logic [WIDTH:0]     add_full, sub_full;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic               mul_hi_nz;
  logic [WIDTH-1:0]   mul_wr;

  // Ready is forced low while reset is held so the bus sees no acceptance window.
  assign cmd_ready = state_ready & rst;
  assign accept    = cmd_valid & cmd_ready;
  assign last_step = (state == S_MUL) && (step_cnt == LAST_STEP);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state and ready decode; only an accepted MUL leaves IDLE.
  always_comb begin
    next_state  = state;
    state_ready = 1'b0;
    case (state)
      S_IDLE: begin
        state_ready = 1'b1;
        if (cmd_valid && rst && cmd_op == OP_MUL) next_state = S_MUL;
      end
      S_MUL: begin
        if (last_step) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Single-cycle ALU result and its overflow/borrow indication.
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} - {1'b0, b};
    alu_res  = '0;
    alu_ovf  = 1'b0;
    case (cmd_op)
      OP_ADD: begin
        alu_ovf = add_full[WIDTH];
`ifdef CATC_EXEC_SAT_EN
        alu_res = add_full[WIDTH] ? {WIDTH{1'b1}} : add_full[WIDTH-1:0];
`else
        alu_res = add_full[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        alu_ovf = sub_full[WIDTH];
`ifdef CATC_EXEC_SAT_EN
        alu_res = sub_full[WIDTH] ? '0 : sub_full[WIDTH-1:0];
`else
        alu_res = sub_full[WIDTH-1:0];
`endif
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand to the high half, then shift right.
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    mul_next  = {mul_sum, prod[WIDTH-1:1]};
    mul_hi_nz = |mul_next[2*WIDTH-1:WIDTH];
`ifdef CATC_EXEC_SAT_EN
    mul_wr    = mul_hi_nz ? {WIDTH{1'b1}} : mul_next[WIDTH-1:0];
`else
    mul_wr    = mul_next[WIDTH-1:0];
`endif
  end

  // Datapath: operand loads, memory writes/reads, multiplier stepping and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a         <= '0;
      b         <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      op_done   <= 1'b0;
      ovf       <= 1'b0;
      prod      <= '0;
      mcand     <= '0;
      mul_addr  <= '0;
      step_cnt  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      op_done   <= 1'b0;
      if (accept) begin
        case (cmd_op)
          OP_LDA: a <= data_in;
          OP_LDB: b <= data_in;
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            mem[cmd_addr] <= alu_res;
            op_done       <= 1'b1;
            if (alu_ovf) ovf <= 1'b1;
          end
          OP_MUL: begin
            mcand    <= a;
            prod     <= {{WIDTH{1'b0}}, b};
            mul_addr <= cmd_addr;
            step_cnt <= '0;
          end
          OP_RD: begin
            data_out  <= mem[cmd_addr];
            out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
      if (state == S_MUL) begin
        prod     <= mul_next;
        step_cnt <= step_cnt + 1'b1;
        if (last_step) begin
          mem[mul_addr] <= mul_wr;
          op_done       <= 1'b1;
          if (mul_hi_nz) ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_catc_exec_unit.sv
// Directed bench for catc_exec_unit with hand-computed expectations.
// Inputs change #1 after a rising edge (or on the falling edge); outputs are sampled #1 after the edge.
// Expectations follow CATC_EXEC_SAT_EN when the bench is built with that macro.
module tb_catc_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_addr;
  logic [19:0] data_in;
  logic [19:0] data_out;
  logic        out_valid;
  logic        op_done;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  catc_exec_unit dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .op_done   (op_done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Count op_done pulses, one sample per cycle.
  always @(negedge clk) if (op_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] addr, input logic [19:0] din);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    data_in   = din;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    int n;
    int d0;
    logic [19:0] exp_sub, exp_mulw, sat_all;
    sat_all = 20'hFFFFF;
`ifdef CATC_EXEC_SAT_EN
    exp_sub  = 20'h00000;
    exp_mulw = 20'hFFFFF;
`else
    exp_sub  = 20'hFFFFF;
    exp_mulw = 20'h00000;
`endif
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_addr  = 4'd0;
    data_in   = 20'd0;
    rst       = 1'b0;

    // Reset state.
    #12;
    check("rst_ready",     32'(cmd_ready), 32'd0);
    check("rst_data_out",  32'(data_out),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_op_done",   32'(op_done),   32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_ready", 32'(cmd_ready), 32'd1);

    // 1 + 2 -> addr 3.
    issue(3'd0, 4'd0, 20'h00001);
    issue(3'd1, 4'd0, 20'h00002);
    d0 = done_cnt;
    issue(3'd2, 4'd3, 20'h0);
    check("add_op_done", 32'(op_done), 32'd1);
    check("add_ovf",     32'(ovf),     32'd0);
    issue(3'd7, 4'd3, 20'h0);
    check("rd3_valid", 32'(out_valid), 32'd1);
    check("rd3_data",  32'(data_out),  32'h00003);
    @(posedge clk);
    #1;
    check("rd3_valid_drop", 32'(out_valid), 32'd0);
    check("rd3_data_hold",  32'(data_out),  32'h00003);
    check("add_done_once",  32'(done_cnt - d0), 32'd1);

    // 1 - 2 -> addr 4, borrow.
    issue(3'd2 + 3'd1, 4'd4, 20'h0);
    check("sub_ovf", 32'(ovf), 32'd1);
    issue(3'd7, 4'd4, 20'h0);
    check("rd4_data", 32'(data_out), 32'(exp_sub));

    // 3 * 5 -> addr 5; an LDA offered while busy must be dropped.
    issue(3'd0, 4'd0, 20'h00003);
    issue(3'd1, 4'd0, 20'h00005);
    issue(3'd6, 4'd5, 20'h0);
    n = 0;
    while (cmd_ready === 1'b0 && n < 100) begin
      n++;
      if (n == 5) begin
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        data_in   = 20'h12345;
      end
      if (n == 15) cmd_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("mul_busy_cycles", 32'(n),       32'd20);
    check("mul_op_done",     32'(op_done), 32'd1);
    issue(3'd7, 4'd5, 20'h0);
    check("rd5_data", 32'(data_out), 32'h0000F);
    issue(3'd2, 4'd8, 20'h0);
    issue(3'd7, 4'd8, 20'h0);
    check("a_kept_after_busy_lda", 32'(data_out), 32'h00008);

    // 0x80000 * 2 overflows the low half.
    do_reset();
    check("rst2_ovf", 32'(ovf), 32'd0);
    issue(3'd0, 4'd0, 20'h80000);
    issue(3'd1, 4'd0, 20'h00002);
    issue(3'd6, 4'd6, 20'h0);
    wait_ready("mul6_ready");
    check("mul6_ovf", 32'(ovf), 32'd1);
    issue(3'd7, 4'd6, 20'h0);
    check("rd6_data", 32'(data_out), 32'(exp_mulw));
    check("rd6_sat_ref", 32'(exp_mulw == sat_all), 32'(data_out == 20'hFFFFF));

    // Reset in the middle of a MUL to addr 7.
    issue(3'd0, 4'd0, 20'h00005);
    issue(3'd1, 4'd0, 20'h00007);
    issue(3'd6, 4'd7, 20'h0);
    repeat (10) @(posedge clk);
    d0 = done_cnt;
    #3;
    rst = 1'b0;
    #1;
    check("abort_ready",     32'(cmd_ready), 32'd0);
    check("abort_data_out",  32'(data_out),  32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_op_done",   32'(op_done),   32'd0);
    check("abort_ovf",       32'(ovf),       32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rel_ready", 32'(cmd_ready), 32'd1);
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    issue(3'd7, 4'd7, 20'h0);
    check("rd7_data", 32'(data_out), 32'h00000);

    // Back-to-back ADD then RD of the same address, plus AND/OR.
    issue(3'd0, 4'd0, 20'h7FFFF);
    issue(3'd1, 4'd0, 20'h00001);
    issue(3'd2, 4'd0, 20'h0);
    check("b2b_add_done", 32'(op_done), 32'd1);
    issue(3'd7, 4'd0, 20'h0);
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_data",  32'(data_out),  32'h80000);
    check("b2b_ovf",   32'(ovf),       32'd0);
    issue(3'd4, 4'd1, 20'h0);
    issue(3'd5, 4'd2, 20'h0);
    issue(3'd7, 4'd1, 20'h0);
    check("and_data", 32'(data_out), 32'h00001);
    issue(3'd7, 4'd2, 20'h0);
    check("or_data", 32'(data_out), 32'h7FFFF);
    check("logic_ovf", 32'(ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/catc_exec_unit.md
Name: catc_exec_unit

Overview:
- Parametrised successor to the CATC 20-bit core's execute path.
- Holds two operand registers (A, B) and a result memory of configurable depth.
- Executes single-cycle add/sub/and/or and a multi-cycle shift-add multiply (CADC-style serial multiplier), with a valid/ready command handshake.
- Sits between the CADC sequencer (command source) and the data bus (data_out consumer).

Parameters:
- WIDTH, 20, data word width in bits.
- MEM_DEPTH, 16, number of result-memory words (power of two, >=2).
- AW, $clog2(MEM_DEPTH), result-memory address width (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  unit can accept a command.
- cmd_op  input  3  opcode: 0 LDA, 1 LDB, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 MUL, 7 RD.
- cmd_addr  input  AW  result-memory address for ops 2-7.
- data_in  input  WIDTH  operand for LDA/LDB.
- data_out  output  WIDTH  last read word.
- out_valid  output  1  one-cycle pulse: data_out updated.
- op_done  output  1  one-cycle pulse: result written to memory.
- ovf  output  1  sticky overflow/borrow flag.

Behaviour:
- Reset (rst low, async):
  - A, B, data_out and all memory words go to 0.
  - out_valid, op_done and ovf go to 0.
  - State goes to IDLE; cmd_ready is 1 once reset is released.
- Accept: a command is accepted on a rising edge where cmd_valid && cmd_ready. Exactly one command is accepted per edge.
- States:
  - IDLE: cmd_ready=1.
  - MUL: cmd_ready=0.
  - IDLE->MUL on accepting op 6. MUL->IDLE on the edge where the step count reaches WIDTH.
- LDA/LDB: A or B <= data_in at the accept edge. No op_done.
- ADD/SUB/AND/OR:
  - mem[cmd_addr] <= result at the accept edge.
  - op_done=1 for the following cycle.
  - ADD: carry-out sets ovf. SUB (A-B): borrow sets ovf. AND/OR never touch ovf.
  - Results are WIDTH bits, wrap modulo 2^WIDTH.
- MUL (unsigned A*B, serial shift-add):
  - Operands and address are captured at accept; one step per clock.
  - Write of the low WIDTH bits happens on the WIDTH-th edge after accept.
  - op_done pulses the cycle after that write.
  - cmd_ready is low for exactly WIDTH cycles.
  - Any nonzero high-half bit sets ovf.
  - A and B are not modified, and may be reloaded only after the MUL returns to IDLE.
- RD:
  - data_out <= mem[cmd_addr] at the accept edge; out_valid=1 for the next cycle.
  - data_out holds its value until the next RD.
  - An RD accepted the cycle after an ADD to the same address returns the new value.
- ovf: sticky; cleared only by reset.
- Reset asserted mid-MUL: operation aborted, no memory write, no op_done.
- Commands presented while cmd_ready=0 are ignored (not queued). The source must hold cmd_valid.

Optional Feature:
- Macro: CATC_EXEC_SAT_EN.
- Defined: saturating arithmetic.
  - ADD overflow and MUL overflow store all-ones.
  - SUB borrow stores 0.
  - ovf is still set.
- Undefined: wrap-around results as above. No saturation logic is built.

Test Plan:
- Reset, LDA 0x00001, LDB 0x00002, ADD addr 3, RD addr 3 -> data_out=0x00003, out_valid one pulse, ovf=0, op_done pulsed once.
- LDA 0x00001, LDB 0x00002, SUB addr 4, RD 4 -> 0xFFFFF with ovf=1 (macro undefined); 0x00000 with ovf=1 (CATC_EXEC_SAT_EN).
- LDA 0x00003, LDB 0x00005, MUL addr 5 -> cmd_ready low exactly 20 cycles, op_done after; RD 5 -> 0x0000F; a cmd_valid LDA issued during busy is ignored (A stays 0x00003).
- LDA 0x80000, LDB 0x00002, MUL addr 6, RD 6 -> 0x00000 with ovf=1 (wrap); 0xFFFFF with ovf=1 (SAT).
- Start MUL to addr 7 (prior content 0x00000), assert rst at step 10 -> all outputs 0 immediately (async); after release cmd_ready=1; RD 7 -> 0x00000, no op_done seen.
- Back-to-back: ADD addr 0 then RD addr 0 on consecutive cycles with A=0x7FFFF, B=0x00001 -> data_out=0x80000, ovf=0.
